prod_accum: RTL

Frame accumulator downstream of the registered 8x8 unsigned multiplier. It consumes the multiplier's 16-bit products and sums LEN consecutive products into one dot-product result. Each result is presented on a valid/ready output port with saturation and an overflow flag. It sits between the multiplier output register and the result consumer (bus interface or next filter stage).

---
 rtl/prod_accum_if.sv | 27 ++
 rtl/prod_accum.sv | 116 +++++++++++
 2 files changed

// File: rtl/prod_accum_if.sv
// Handshake bundle between the multiplier, the frame accumulator and the result consumer.
// Carries the product stream (valid/ready) and the saturated result stream (valid/ready).
// Producer/consumer side uses master; the accumulator uses slave.
interface prod_accum_if #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24
) ();
  // Product stream from the multiplier output register
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  // Result stream towards the consumer
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/prod_accum.sv
// Sums LEN consecutive unsigned products into one saturated frame result with a sticky overflow flag.
// Latency: result valid on the edge that accepts the LENth product; one product per cycle.
// Backpressure: non-final products always accepted; only the final product stalls while a result is held.
module prod_accum #(
  parameter int IN_W  = 16,  // product width
  parameter int ACC_W = 24,  // accumulator/result width, must be >= IN_W
  parameter int LEN   = 8    // products per frame, 2..255
) (
  input  logic       clk_i,
  input  logic       rst_i,   // asynchronous, active-low
  input  logic       clr_i,   // synchronous frame abort
  output logic [7:0] fill_o,  // products accepted in the current frame
  prod_accum_if.slave bus
);

  // Zero-extension needed to bring a product up to the adder width (ACC_W+1).
  localparam int         EXT_W    = ACC_W + 1 - IN_W;
  localparam logic [7:0] LAST_CNT = 8'(LEN - 1);

  // Running frame state
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       cnt_q, cnt_d;

  // Held result
  logic [ACC_W-1:0] odat_q, odat_d;
  logic             oovf_q, oovf_d;
  logic             ovld_q, ovld_d;

  // Datapath / control nets
  logic [ACC_W:0]   sum_w;
  logic             sum_ovf_w;
  logic [ACC_W-1:0] sum_sat_w;
  logic             last_w;
  logic             stall_w;
  logic             in_rdy_w;
  logic             accept_w;
  logic             xfer_w;

  // Single adder: one extra bit catches the carry out of the accumulator width.
  assign sum_w     = {1'b0, acc_q} + {{EXT_W{1'b0}}, bus.in_data};
  // Overflow is sticky for the frame; once set the value stays clamped at all-ones.
  assign sum_ovf_w = sum_w[ACC_W] | ovf_q;
  assign sum_sat_w = sum_ovf_w ? {ACC_W{1'b1}} : sum_w[ACC_W-1:0];

  // Single comparator: is the next product the one that closes the frame.
  assign last_w    = (cnt_q == LAST_CNT);
  // Only the closing product has to wait for the output register to free up.
  assign stall_w   = last_w & ovld_q & ~bus.out_ready;
  // Ready is low throughout reset so the producer never sees a false accept.
  assign in_rdy_w  = rst_i & ~stall_w;
  // Abort wins over a coincident product; that product is simply dropped.
  assign accept_w  = bus.in_valid & in_rdy_w & ~clr_i;
  assign xfer_w    = ovld_q & bus.out_ready;

  // Next-state for the running sum, the frame counter and the output register.
  always_comb begin
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    odat_d = odat_q;
    oovf_d = oovf_q;
    ovld_d = ovld_q;

    // A taken result frees the register; a same-cycle final accept below re-fills it.
    if (xfer_w) begin
      ovld_d = 1'b0;
    end

    if (clr_i) begin
      // Abort only touches the running frame, a held result still goes out.
      acc_d = '0;
      ovf_d = 1'b0;
      cnt_d = '0;
    end else if (accept_w) begin
      if (last_w) begin
        odat_d = sum_sat_w;
        oovf_d = sum_ovf_w;
        ovld_d = 1'b1;
        acc_d  = '0;
        ovf_d  = 1'b0;
        cnt_d  = '0;
      end else begin
        acc_d  = sum_sat_w;
        ovf_d  = sum_ovf_w;
        cnt_d  = cnt_q + 8'd1;
      end
    end
  end

  // State registers; reset discards both the partial frame and any pending result.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      odat_q <= '0;
      oovf_q <= 1'b0;
      ovld_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      odat_q <= odat_d;
      oovf_q <= oovf_d;
      ovld_q <= ovld_d;
    end
  end

  assign bus.in_ready  = in_rdy_w;
  assign bus.out_valid = ovld_q;
  assign bus.out_data  = odat_q;
  assign bus.out_ovf   = oovf_q;
  assign fill_o        = cnt_q;

endmodule
